idelay_tap_scanner: RTL

- Drives the variable-load control interface of an IDELAYE2 in VAR_LOAD mode and sweeps all 32 taps.
- At each tap it verifies the tap readback, then checks whether the delayed input still shows the clock-rate toggle pattern. The far end of the loopback transmits this pattern by inverting its output every clock.
- Reports a per-tap pass mask, picks the centre of the widest passing window, and leaves the delay line loaded with that tap.
- Sits between idelay_calibrator (gated by its rdy) and the IDELAYE2 LD/CNTVALUEIN/CNTVALUEOUT/DATAOUT pins.

---
 rtl/idelay_tap_scanner_if.sv | 46 ++++
 rtl/idelay_tap_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_tap_scanner_if.sv
// IDELAYE2 tap scanner bus: calibrator gating, delay-line
// control/readback, sampled data and scan results.
interface idelay_tap_scanner_if;
    logic        cal_rdy;
    logic        start;
    logic        dly_ld;
    logic [4:0]  dly_cntvaluein;
    logic [4:0]  dly_cntvalueout;
    logic        data_in;
    logic        busy;
    logic        done;
    logic [31:0] pass_mask;
    logic [4:0]  best_tap;
    logic        best_valid;
    logic        tap_err;

    modport master (
        input  cal_rdy,
        input  start,
        input  dly_cntvalueout,
        input  data_in,
        output dly_ld,
        output dly_cntvaluein,
        output busy,
        output done,
        output pass_mask,
        output best_tap,
        output best_valid,
        output tap_err
    );

    modport slave (
        output cal_rdy,
        output start,
        output dly_cntvalueout,
        output data_in,
        input  dly_ld,
        input  dly_cntvaluein,
        input  busy,
        input  done,
        input  pass_mask,
        input  best_tap,
        input  best_valid,
        input  tap_err
    );
endinterface

// File: rtl/idelay_tap_scanner.sv
// Sweeps all 32 IDELAYE2 taps, checks readback and toggle
// integrity, then loads the centre of the widest passing window.
module idelay_tap_scanner #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_LOG2   = 10,
    parameter int unsigned ERR_THRESHOLD = 0
) (
    input logic clk,
    input logic rst_n,
    idelay_tap_scanner_if.master bus
);
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ?
                                 $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned WW = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
    localparam int unsigned EW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] CLOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WLAST = WW'((1 << WINDOW_LOG2) - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_MEASURE,
        S_NEXT,
        S_ANALYZE,
        S_APPLY,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    tap_q, tap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [EW-1:0] errcnt_q, errcnt_d;
    logic [31:0]   mask_q, mask_d;
    logic          terr_q, terr_d;
    logic          bvalid_q, bvalid_d;
    logic [4:0]    btap_q, btap_d;
    logic [4:0]    cval_q, cval_d;
    logic          prev_q, prev_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    cstart_q, cstart_d;
    logic [5:0]    clen_q, clen_d;
    logic [4:0]    bstart_q, bstart_d;
    logic [5:0]    blen_q, blen_d;

    logic          hit;
    logic [EW-1:0] err_next;
    logic [4:0]    a_start;
    logic [5:0]    a_len;
    logic [4:0]    b_start;
    logic [5:0]    b_len;
    logic [4:0]    mid;
    logic [4:0]    pick;

    // Results and delay-line control are registered; strobes decode state.
    assign bus.dly_ld         = (state_q == S_LOAD) || (state_q == S_APPLY);
    assign bus.dly_cntvaluein = cval_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass_mask      = mask_q;
    assign bus.best_tap       = btap_q;
    assign bus.best_valid     = bvalid_q;
    assign bus.tap_err        = terr_q;

    // Next-state logic: scan sequencing, window measurement, run search.
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        errcnt_d = errcnt_q;
        mask_d   = mask_q;
        terr_d   = terr_q;
        bvalid_d = bvalid_q;
        btap_d   = btap_q;
        cval_d   = cval_q;
        prev_d   = bus.data_in;
        idx_d    = idx_q;
        cstart_d = cstart_q;
        clen_d   = clen_q;
        bstart_d = bstart_q;
        blen_d   = blen_q;

        // A missing toggle shows up as two equal consecutive samples.
        hit = (bus.data_in == prev_q);
        if (hit && !(&errcnt_q)) begin
            err_next = errcnt_q + EW'(1);
        end else begin
            err_next = errcnt_q;
        end

        if (mask_q[idx_q]) begin
            a_start = (clen_q == 6'd0) ? idx_q : cstart_q;
            a_len   = clen_q + 6'd1;
        end else begin
            a_start = cstart_q;
            a_len   = 6'd0;
        end
        // Strict compare keeps the earliest of equally long runs.
        if (a_len > blen_q) begin
            b_start = a_start;
            b_len   = a_len;
        end else begin
            b_start = bstart_q;
            b_len   = blen_q;
        end
        mid  = 5'((b_len - 6'd1) >> 1);
        pick = (b_len == 6'd0) ? 5'd0 : b_start + mid;

        if (state_q != S_IDLE && !bus.cal_rdy) begin
            state_d  = S_IDLE;
            bvalid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && bus.cal_rdy) begin
                        state_d  = S_LOAD;
                        tap_d    = 5'd0;
                        cval_d   = 5'd0;
                        mask_d   = 32'd0;
                        terr_d   = 1'b0;
                        bvalid_d = 1'b0;
                        btap_d   = 5'd0;
                    end
                end
                S_LOAD: begin
                    state_d = S_SETTLE;
                    cnt_d   = CLOAD;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_CHECK: begin
                    if (bus.dly_cntvalueout != tap_q) begin
                        terr_d        = 1'b1;
                        mask_d[tap_q] = 1'b0;
                        state_d       = S_NEXT;
                    end else begin
                        wcnt_d   = '0;
                        errcnt_d = '0;
                        state_d  = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    errcnt_d = err_next;
                    wcnt_d   = wcnt_q + WW'(1);
                    if (wcnt_q == WLAST) begin
                        mask_d[tap_q] = (32'(err_next) <= ERR_THRESHOLD);
                        state_d       = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (tap_q == 5'd31) begin
                        state_d  = S_ANALYZE;
                        idx_d    = 5'd0;
                        cstart_d = 5'd0;
                        clen_d   = 6'd0;
                        bstart_d = 5'd0;
                        blen_d   = 6'd0;
                    end else begin
                        tap_d   = tap_q + 5'd1;
                        cval_d  = tap_q + 5'd1;
                        state_d = S_LOAD;
                    end
                end
                S_ANALYZE: begin
                    cstart_d = a_start;
                    clen_d   = a_len;
                    bstart_d = b_start;
                    blen_d   = b_len;
                    idx_d    = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        bvalid_d = (b_len != 6'd0);
                        btap_d   = pick;
                        cval_d   = pick;
                        state_d  = S_APPLY;
                    end
                end
                S_APPLY: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            errcnt_q <= '0;
            mask_q   <= '0;
            terr_q   <= 1'b0;
            bvalid_q <= 1'b0;
            btap_q   <= '0;
            cval_q   <= '0;
            prev_q   <= 1'b0;
            idx_q    <= '0;
            cstart_q <= '0;
            clen_q   <= '0;
            bstart_q <= '0;
            blen_q   <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            errcnt_q <= errcnt_d;
            mask_q   <= mask_d;
            terr_q   <= terr_d;
            bvalid_q <= bvalid_d;
            btap_q   <= btap_d;
            cval_q   <= cval_d;
            prev_q   <= prev_d;
            idx_q    <= idx_d;
            cstart_q <= cstart_d;
            clen_q   <= clen_d;
            bstart_q <= bstart_d;
            blen_q   <= blen_d;
        end
    end
endmodule
